// File: rtl/cpu_decode_execute_skid_if.sv
// Decode->execute handshake bundle for the skid stage.
// The slave modport is the skid's view. The master modport is the decode/execute environment.
interface cpu_decode_execute_skid_if #(
  parameter int ALU_OP_W = 3,
  parameter int MODE_W   = 2,
  parameter int VADDR_W  = 32,
  parameter int REG_W    = 32,
  parameter int RID_W    = 5
);
  localparam int PAYLOAD_W = 2 + (2 + MODE_W) + (ALU_OP_W + 1) + 2 + VADDR_W + 3*REG_W + 3*RID_W;

  logic                 dec_valid;
  logic                 dec_ready;
  logic [PAYLOAD_W-1:0] dec_payload;
  logic                 ex_valid;
  logic                 ex_ready;
  logic [PAYLOAD_W-1:0] ex_payload;
  logic                 flush;
  logic [1:0]           occupancy;

  modport master (
    output dec_valid, dec_payload, ex_ready, flush,
    input  dec_ready, ex_valid, ex_payload, occupancy
  );

  modport slave (
    input  dec_valid, dec_payload, ex_ready, flush,
    output dec_ready, ex_valid, ex_payload, occupancy
  );
endinterface

// File: rtl/cpu_decode_execute_skid.sv
// Two-entry skid buffer between decode and execute.
// All handshake outputs are registered, so dec_ready never combinationally sees ex_ready.
module cpu_decode_execute_skid #(
  parameter int ALU_OP_W = 3,
  parameter int MODE_W   = 2,
  parameter int VADDR_W  = 32,
  parameter int REG_W    = 32,
  parameter int RID_W    = 5
) (
  input logic                     clk,
  input logic                     reset,
  cpu_decode_execute_skid_if.slave bus
);
  localparam int PAYLOAD_W = 2 + (2 + MODE_W) + (ALU_OP_W + 1) + 2 + VADDR_W + 3*REG_W + 3*RID_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e               state, state_nx;
  logic [PAYLOAD_W-1:0] main_q, skid_q;
  logic                 dec_ready_q, ex_valid_q;
  logic [1:0]           occupancy_q;
  logic                 load_main, load_skid, main_from_skid;

  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (bus.flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (bus.dec_valid) begin
          load_main = 1'b1;
          state_nx  = BUSY;
        end
        BUSY: begin
          unique case ({bus.dec_valid, bus.ex_ready})
            2'b11: load_main = 1'b1;
            2'b10: begin
              load_skid = 1'b1;
              state_nx  = FULL;
            end
            2'b01: state_nx = EMPTY;
            default: ;
          endcase
        end
        FULL: if (bus.ex_ready) begin
          main_from_skid = 1'b1;
          state_nx       = BUSY;
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  // Outputs are derived from the next state, which keeps them registered without adding a cycle of lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      dec_ready_q <= 1'b1;
      ex_valid_q  <= 1'b0;
      occupancy_q <= '0;
    end else begin
      state <= state_nx;
      if (load_main) begin
        main_q <= bus.dec_payload;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= bus.dec_payload;
      end
      dec_ready_q <= (state_nx != FULL);
      ex_valid_q  <= (state_nx != EMPTY);
      occupancy_q <= state_nx;
    end
  end

  assign bus.dec_ready  = dec_ready_q;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_payload = main_q;
  assign bus.occupancy  = occupancy_q;
endmodule

// File: tb/tb_cpu_decode_execute_skid.sv
// Scoreboard bench for cpu_decode_execute_skid: accepted bundles are queued, and the negedge monitor pops and compares them.
// Directed stimulus drives the state checks, and a short random phase exercises ordering.
module tb_cpu_decode_execute_skid;
  localparam int PW = 155;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_decode_execute_skid_if #(.ALU_OP_W(3), .MODE_W(2), .VADDR_W(32), .REG_W(32), .RID_W(5)) bus ();

  cpu_decode_execute_skid #(.ALU_OP_W(3), .MODE_W(2), .VADDR_W(32), .REG_W(32), .RID_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void check_i(string name, int act, int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // next_PC sits at [142:111], so mk(0) carries next_PC = 0x100.
  function automatic logic [PW-1:0] mk(int i);
    logic [PW-1:0] p;
    logic [31:0]   u;
    u = 32'(i);
    p = '0;
    p[14:0]    = 15'(u*3 + 5);
    p[46:15]   = 32'hA500_0000 ^ u;
    p[78:47]   = 32'h5A00_0000 + u;
    p[110:79]  = 32'hC0DE_0000 | u;
    p[142:111] = 32'h100 + 4*u;
    p[154:143] = 12'(u*7 + 1);
    return p;
  endfunction

  // Scoreboard monitor
  logic [PW-1:0] sb_q[$];
  logic          hold_prev = 1'b0;
  logic [PW-1:0] prev_payload = '0;

  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) check("hold", bus.ex_payload, prev_payload);
      if (bus.flush) begin
        sb_q.delete();
      end else begin
        if (bus.ex_valid && bus.ex_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_underflow: got %h expected no output", bus.ex_payload);
          end else begin
            check("sb_order", bus.ex_payload, sb_q.pop_front());
          end
        end
        if (bus.dec_valid && bus.dec_ready) sb_q.push_back(bus.dec_payload);
      end
      hold_prev    = bus.ex_valid && !bus.ex_ready && !bus.flush;
      prev_payload = bus.ex_payload;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [PW-1:0] p, input logic r, input logic f);
    bus.dec_valid   = v;
    bus.dec_payload = p;
    bus.ex_ready    = r;
    bus.flush       = f;
  endtask

  initial begin
    logic r0;
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    check_i("rst_ex_valid", int'(bus.ex_valid), 0);
    check_i("rst_dec_ready", int'(bus.dec_ready), 1);
    check_i("rst_occ", int'(bus.occupancy), 0);
    check("rst_payload", bus.ex_payload, '0);

    // first transfer
    drive(1'b1, mk(0), 1'b1, 1'b0);
    tick();
    check_i("p0_valid", int'(bus.ex_valid), 1);
    check("p0_payload", bus.ex_payload, mk(0));
    check_i("p0_next_pc", int'(bus.ex_payload[142:111]), 32'h100);
    check_i("p0_occ", int'(bus.occupancy), 1);

    // full-throughput stream
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, mk(i), 1'b1, 1'b0);
      check_i("stream_ready", int'(bus.dec_ready), 1);
      tick();
      check("stream_payload", bus.ex_payload, mk(i));
      check_i("stream_occ", int'(bus.occupancy), 1);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check_i("stream_empty_occ", int'(bus.occupancy), 0);
    check_i("stream_empty_valid", int'(bus.ex_valid), 0);

    // backpressure into FULL, then drain
    drive(1'b1, mk(20), 1'b0, 1'b0);
    tick();
    check_i("bp_busy_occ", int'(bus.occupancy), 1);
    drive(1'b1, mk(21), 1'b0, 1'b0);
    tick();
    check_i("bp_full_occ", int'(bus.occupancy), 2);
    check_i("bp_full_ready", int'(bus.dec_ready), 0);
    check("bp_full_payload", bus.ex_payload, mk(20));
    drive(1'b1, mk(22), 1'b0, 1'b0);
    tick();
    check_i("bp_ignored_occ", int'(bus.occupancy), 2);
    check("bp_ignored_payload", bus.ex_payload, mk(20));
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check("bp_drain_payload", bus.ex_payload, mk(21));
    check_i("bp_drain_occ", int'(bus.occupancy), 1);
    check_i("bp_drain_ready", int'(bus.dec_ready), 1);
    tick();
    check_i("bp_empty_occ", int'(bus.occupancy), 0);

    // flush from FULL with a bundle offered
    drive(1'b1, mk(30), 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(31), 1'b0, 1'b0);
    tick();
    check_i("fl_pre_occ", int'(bus.occupancy), 2);
    drive(1'b1, mk(32), 1'b1, 1'b1);
    tick();
    check_i("fl_occ", int'(bus.occupancy), 0);
    check_i("fl_valid", int'(bus.ex_valid), 0);
    check_i("fl_ready", int'(bus.dec_ready), 1);
    tick();
    check_i("fl_twice_occ", int'(bus.occupancy), 0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check_i("fl_after_valid", int'(bus.ex_valid), 0);
    // flush from BUSY with simultaneous in and out
    drive(1'b1, mk(33), 1'b1, 1'b0);
    tick();
    drive(1'b1, mk(34), 1'b1, 1'b1);
    tick();
    check_i("fl_busy_occ", int'(bus.occupancy), 0);
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    check_i("fl_busy_after_valid", int'(bus.ex_valid), 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 50, mk(1000 + i), $urandom_range(0, 99) < 30,
            $urandom_range(0, 199) == 0);
      if (i % 50 == 0) begin
        r0 = bus.dec_ready;
        #1 bus.ex_ready = ~bus.ex_ready;
        #1 check_i("ready_indep", int'(bus.dec_ready), int'(r0));
        bus.ex_ready = ~bus.ex_ready;
      end
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (4) tick();
    check_i("drained", sb_q.size(), 0);

    // asynchronous reset while FULL
    drive(1'b1, mk(40), 1'b0, 1'b0);
    tick();
    drive(1'b1, mk(41), 1'b0, 1'b0);
    tick();
    check_i("ar_full_occ", int'(bus.occupancy), 2);
    #2 reset = 1'b1;
    #1;
    check_i("ar_valid", int'(bus.ex_valid), 0);
    check_i("ar_ready", int'(bus.dec_ready), 1);
    check_i("ar_occ", int'(bus.occupancy), 0);
    check("ar_payload", bus.ex_payload, '0);
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_i("ar_post_ready", int'(bus.dec_ready), 1);
    check_i("ar_post_occ", int'(bus.occupancy), 0);
    drive(1'b1, mk(50), 1'b1, 1'b0);
    tick();
    check("ar_post_payload", bus.ex_payload, mk(50));
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    tick();
    check_i("final_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
